// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//   Single-word SPI bus controller. It accepts a parallel word on a valid/ready
//   request, frames it with chip select and shifts it out MSB first in any of
//   the four SPI modes. At the same time it shifts in the responder's word,
//   which is returned as a one-cycle parallel pulse.
//
// Parameters
//   DATA_W   bits per transfer (>= 2)
//   CLK_DIV  clk cycles per sclk half-period (>= 2)
//   CPOL     sclk idle level
//   CPHA     0: sample on leading edge, shift on trailing edge
//            1: shift on leading edge, sample on trailing edge
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_valid  in   transmit request
//   tx_ready  out  controller can accept tx_data
//   tx_data   in   word to send, MSB first
//   rx_valid  out  one-cycle pulse, rx_data valid
//   rx_data   out  word received on sdo (held until next rx_valid)
//   busy      out  high in every state except IDLE
//   csn       out  chip select, active low
//   sclk      out  serial clock
//   sdi       out  controller-to-responder data
//   sdo       in   responder-to-controller data (treated as clk-synchronous)
//
// Handshake: a word is transferred on every rising clk edge where
// tx_valid && tx_ready. tx_ready is high only in IDLE, so tx_valid and tx_data
// are ignored (not sampled) at all other times. rx_valid has no backpressure.
// -----------------------------------------------------------------------------
module spi_controller #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              csn,
  output logic              sclk,
  output logic              sdi,
  input  logic              sdo
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_XFER  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;     // sclk edges already produced
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic                csn_q, csn_d;
  logic                sclk_q, sclk_d;
  logic                sdi_q, sdi_d;
  logic                tx_ready_q, tx_ready_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;

  logic tick;
  logic odd_edge;
  logic sample_edge;
  logic last_edge;

  assign tick        = (div_q == DIV_W'(CLK_DIV - 1));
  // The edge about to be produced is edge_q+1; it is odd (leading) when
  // edge_q is even.
  assign odd_edge    = ~edge_q[0];
  assign sample_edge = odd_edge ^ CPHA;
  assign last_edge   = (edge_q == EDGE_W'(2 * DATA_W - 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_d     = edge_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    csn_d      = csn_q;
    sclk_d     = sclk_q;
    sdi_d      = sdi_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;

    if (state_q != ST_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        edge_d = '0;
        if (tx_valid && tx_ready_q) begin
          state_d    = ST_LEAD;
          tx_ready_d = 1'b0;
          csn_d      = 1'b0;
          busy_d     = 1'b1;
          rx_sh_d    = '0;
          if (CPHA) begin
            tx_sh_d = tx_data;
          end else begin
            // MSB goes out with the csn fall; the register keeps the rest.
            sdi_d   = tx_data[DATA_W-1];
            tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
          end
        end
      end

      ST_LEAD: begin
        if (tick) state_d = ST_XFER;
      end

      ST_XFER: begin
        if (tick) begin
          edge_d = edge_q + EDGE_W'(1);
          sclk_d = ~sclk_q;
          if (sample_edge) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], sdo};
          end else if (CPHA || !last_edge) begin
            // With CPHA=0 the final trailing edge has no bit left to drive.
            sdi_d   = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
          end
          if (last_edge) state_d = ST_TRAIL;
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          state_d    = ST_GAP;
          csn_d      = 1'b1;
          sdi_d      = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_d    = ST_IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      csn_q      <= 1'b1;
      sclk_q     <= CPOL;
      sdi_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      csn_q      <= csn_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign csn      = csn_q;
  assign sclk     = sclk_q;
  assign sdi      = sdi_q;

endmodule
